// File: rtl/sif_wr_bridge.sv
// Host write/read bridge: host writes are buffered in a FIFO and drained to one of NCH
// write-out channels under per-channel backpressure; reads come from a shadow register bank.
module sif_wr_bridge #(
  parameter int AW    = 16,
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int NCH   = 2,
  parameter int NREG  = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           xa_wr_s,
  input  logic           xa_rd_s,
  input  logic [AW-1:0]  xa_addr,
  input  logic [DW-1:0]  xa_data_wr,
  output logic           xa_ready,
  output logic [DW-1:0]  xa_data_rd,
  output logic           xa_rd_valid,
  output logic           xa_ovf,
  output logic [7:0]     drop_cnt,
  output logic [NCH-1:0] wa_wr_s,
  input  logic [NCH-1:0] wa_ready,
  output logic [AW-1:0]  wa_addr,
  output logic [DW-1:0]  wa_data_wr,
  output logic           drain_state
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 0;
  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(NREG);

  // Handshake: a word leaves when wa_wr_s[ch] and wa_ready[ch] are both high at a rising edge.
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
  state_t state;

  logic [AW+DW-1:0] mem [DEPTH];
  logic [DW-1:0]    shadow [NREG];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             full, push, pop, out_done;
  logic [AW+DW-1:0] head;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic [NCH-1:0]   head_oh;
  logic [IW-1:0]    idx;

  assign full        = (count == (PW+1)'(DEPTH));
  assign xa_ready    = !full;
  assign push        = xa_wr_s && !full;
  assign idx         = xa_addr[IW-1:0];
  assign head        = mem[rd_ptr];
  assign head_addr   = head[AW+DW-1:DW];
  assign head_data   = head[DW-1:0];
  assign drain_state = (state == SEND);

  // A word routed to a channel index >= NCH has an all-zero strobe and is retired at once.
  assign out_done = (state == SEND) && (((wa_wr_s & wa_ready) != '0) || (wa_wr_s == '0));
  assign pop      = (count != '0) && ((state == IDLE) || out_done);

  generate
    if (NCH > 1) begin : g_multi
      always_comb begin
        head_oh = '0;
        for (int i = 0; i < NCH; i++)
          if (int'(head_addr[AW-1 -: CW]) == i) head_oh[i] = 1'b1;
      end
    end else begin : g_single
      assign head_oh = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {xa_addr, xa_data_wr};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wa_wr_s     <= '0;
      wa_addr     <= '0;
      wa_data_wr  <= '0;
      xa_rd_valid <= 1'b0;
      xa_ovf      <= 1'b0;
      xa_data_rd  <= '0;
      drop_cnt    <= '0;
      for (int i = 0; i < NREG; i++) shadow[i] <= '0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PW'(1);
        shadow[idx] <= xa_data_wr;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: ;
      endcase

      xa_ovf <= xa_wr_s && full;
      if (xa_wr_s && full && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      // Reads share xa_addr with writes, so an accepted write always targets the read index.
      xa_rd_valid <= xa_rd_s;
      if (xa_rd_s) xa_data_rd <= push ? xa_data_wr : shadow[idx];

      if (pop) begin
        state      <= SEND;
        wa_addr    <= head_addr;
        wa_data_wr <= head_data;
        wa_wr_s    <= head_oh;
      end else if (out_done) begin
        state   <= IDLE;
        wa_wr_s <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sif_wr_bridge.sv
// Directed bench for sif_wr_bridge (AW=DW=16, DEPTH=4, NCH=2, NREG=16) with an ordered
// scoreboard of expected write-out words {one-hot, addr, data}.
module tb_sif_wr_bridge;

  logic        clk, rst;
  logic        xa_wr_s, xa_rd_s;
  logic [15:0] xa_addr, xa_data_wr;
  logic        xa_ready, xa_rd_valid, xa_ovf;
  logic [15:0] xa_data_rd;
  logic [7:0]  drop_cnt;
  logic [1:0]  wa_wr_s, wa_ready;
  logic [15:0] wa_addr, wa_data_wr;
  logic        drain_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [33:0] exp_q[$];
  logic [33:0] mon_e;

  sif_wr_bridge #(.AW(16), .DW(16), .DEPTH(4), .NCH(2), .NREG(16)) dut (
    .clk(clk), .rst(rst),
    .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s), .xa_addr(xa_addr), .xa_data_wr(xa_data_wr),
    .xa_ready(xa_ready), .xa_data_rd(xa_data_rd), .xa_rd_valid(xa_rd_valid),
    .xa_ovf(xa_ovf), .drop_cnt(drop_cnt),
    .wa_wr_s(wa_wr_s), .wa_ready(wa_ready), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr),
    .drain_state(drain_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] chan_oh(input logic [15:0] a);
    return a[15] ? 2'b10 : 2'b01;
  endfunction

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input bit acc);
    xa_wr_s    = 1'b1;
    xa_addr    = a;
    xa_data_wr = d;
    if (acc) exp_q.push_back({chan_oh(a), a, d});
    tick();
    xa_wr_s = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    xa_rd_s = 1'b1;
    xa_addr = a;
    tick();
    xa_rd_s = 1'b0;
    check({tag, "_valid"}, 64'(xa_rd_valid), 64'(1));
    check({tag, "_data"}, 64'(xa_data_rd), 64'(exp));
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    check(tag, 64'(exp_q.size()), 64'(0));
    tick();
    check({tag, "_idle"}, 64'(wa_wr_s), 64'(0));
  endtask

  // scoreboard: a word is retired when strobe and ready of its channel meet at the next edge
  always @(negedge clk) begin
    if (!rst && ((wa_wr_s & wa_ready) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        check("wa_unexpected", 64'(1), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("wa_word", 64'({wa_wr_s, wa_addr, wa_data_wr}), 64'(mon_e));
      end
    end
  end

  initial begin
    rst = 1'b1; xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_addr = '0; xa_data_wr = '0; wa_ready = 2'b00;
    #12;
    check("rst_ready", 64'(xa_ready), 64'(1));
    check("rst_strobe", 64'(wa_wr_s), 64'(0));
    check("rst_drop", 64'(drop_cnt), 64'(0));
    check("rst_outs", 64'({xa_rd_valid, xa_ovf, xa_data_rd, wa_addr, wa_data_wr}), 64'(0));
    check("rst_state", 64'(drain_state), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // T1 single write, then read back through the shadow bank
    wa_ready = 2'b11;
    wr(16'h8003, 16'hBEEF, 1'b1);
    check("t1_no_strobe_yet", 64'(wa_wr_s), 64'(0));
    tick();
    check("t1_strobe", 64'(wa_wr_s), 64'(2'b10));
    check("t1_addr", 64'(wa_addr), 64'(16'h8003));
    check("t1_data", 64'(wa_data_wr), 64'(16'hBEEF));
    check("t1_state", 64'(drain_state), 64'(1));
    tick();
    rd(16'h0003, 16'hBEEF, "t1_rd");
    tick();
    check("t1_rd_pulse", 64'(xa_rd_valid), 64'(0));
    check("t1_rd_hold", 64'(xa_data_rd), 64'(16'hBEEF));

    // T2 overflow with blocked sink; 6th write dropped alongside a read of its index
    wa_ready = 2'b00;
    for (int i = 0; i < 5; i++) wr(16'h0010 + 16'(i), 16'hA000 + 16'(i), 1'b1);
    check("t2_full", 64'(xa_ready), 64'(0));
    check("t2_no_ovf", 64'(xa_ovf), 64'(0));
    xa_rd_s = 1'b1;
    wr(16'h0015, 16'hA005, 1'b0);
    xa_rd_s = 1'b0;
    check("t2_ovf", 64'(xa_ovf), 64'(1));
    check("t2_drop", 64'(drop_cnt), 64'(1));
    check("t2_ready", 64'(xa_ready), 64'(0));
    check("t2_rd_valid", 64'(xa_rd_valid), 64'(1));
    check("t2_rd_drop", 64'(xa_data_rd), 64'(0));
    wa_ready = 2'b10;
    tick();
    check("t2_ovf_pulse", 64'(xa_ovf), 64'(0));
    tick();
    check("t2_hold_strobe", 64'(wa_wr_s), 64'(2'b01));
    check("t2_hold_addr", 64'(wa_addr), 64'(16'h0010));
    check("t2_hold_data", 64'(wa_data_wr), 64'(16'hA000));
    wa_ready = 2'b01;
    drain("t2_drain");

    // T3 write-first read
    wa_ready = 2'b11;
    xa_rd_s = 1'b1;
    wr(16'h0005, 16'h1234, 1'b1);
    xa_rd_s = 1'b0;
    check("t3_valid", 64'(xa_rd_valid), 64'(1));
    check("t3_data", 64'(xa_data_rd), 64'(16'h1234));
    drain("t3_drain");

    // T4 streaming, alternating channels, strobe expected on ticks 2..9
    for (int t = 1; t <= 10; t++) begin
      if (t <= 8) begin
        xa_wr_s    = 1'b1;
        xa_addr    = (t[0] ? 16'h0000 : 16'h8000) | (16'h0020 + 16'(t));
        xa_data_wr = 16'h5500 + 16'(t);
        exp_q.push_back({chan_oh(xa_addr), xa_addr, xa_data_wr});
      end else begin
        xa_wr_s = 1'b0;
      end
      tick();
      check("t4_strobe", 64'(wa_wr_s != 2'b00), 64'((t >= 2 && t <= 9) ? 1 : 0));
    end
    xa_wr_s = 1'b0;
    check("t4_all_out", 64'(exp_q.size()), 64'(0));

    // T5 asynchronous reset with words queued behind a blocked sink
    wa_ready = 2'b00;
    for (int i = 0; i < 3; i++) wr(16'h8040 + 16'(i), 16'hC000 + 16'(i), 1'b1);
    tick();
    check("t5_busy", 64'(wa_wr_s), 64'(2'b10));
    #2 rst = 1'b1;
    #1;
    check("t5_strobe", 64'(wa_wr_s), 64'(0));
    check("t5_ready", 64'(xa_ready), 64'(1));
    check("t5_state", 64'(drain_state), 64'(0));
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    wa_ready = 2'b11;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("t5_no_stale", 64'(wa_wr_s), 64'(0));
    end
    rd(16'h0003, 16'h0000, "t5_rd3");
    rd(16'h0005, 16'h0000, "t5_rd5");

    // T6 drop counter saturation
    wa_ready = 2'b00;
    for (int i = 0; i < 5; i++) wr(16'h0007, 16'h7000 + 16'(i), 1'b1);
    xa_wr_s = 1'b1; xa_addr = 16'h0007; xa_data_wr = 16'hDEAD;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254) check("t6_cnt254", 64'(drop_cnt), 64'(254));
      if (i == 256) check("t6_cnt256", 64'(drop_cnt), 64'(255));
    end
    xa_wr_s = 1'b0;
    check("t6_ovf", 64'(xa_ovf), 64'(1));
    check("t6_sat", 64'(drop_cnt), 64'(255));
    tick();
    check("t6_ovf_end", 64'(xa_ovf), 64'(0));
    check("t6_sat_hold", 64'(drop_cnt), 64'(255));
    rd(16'h0007, 16'h7004, "t6_rd");
    wa_ready = 2'b01;
    drain("t6_drain");

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
